// File: rtl/cdc_handshake_tx.sv
// Source-domain end of a 4-phase req/ack crossing: captures one word, holds it on o_xdata
// and walks req-up/ack-up/req-down/ack-down. Define CDC_TIMEOUT_EN to add the ack-wait watchdog.
module cdc_handshake_tx #(
    parameter int WIDTH          = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_xreq,
    output logic [WIDTH-1:0] o_xdata,
    input  logic             i_xack,
    output logic             o_done,
    output logic             o_busy,
    output logic             o_timeout
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_xreq;
    logic [WIDTH-1:0]       r_xdata;
    logic                   r_done;
    logic                   w_ack_s;

    // i_xack is asynchronous; only the last synchronizer stage is ever looked at
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_xack};
        end
    end

    assign w_ack_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_xreq  <= 1'b0;
            r_xdata <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_xdata <= i_data;
                        r_xreq  <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (w_ack_s) begin
                        r_xreq  <= 1'b0;
                        r_state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!w_ack_s) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_xreq  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ready = (r_state == S_IDLE);
    assign o_busy  = (r_state != S_IDLE);
    assign o_xreq  = r_xreq;
    assign o_xdata = r_xdata;
    assign o_done  = r_done;

`ifdef CDC_TIMEOUT_EN
    localparam int             CW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  TO_MAX = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] r_wait_cnt;
    logic          r_timeout;
    logic          w_waiting;

    // Waiting means staying put in REQ or RELEASE; any state change restarts the count
    assign w_waiting = ((r_state == S_REQ) && !w_ack_s) ||
                       ((r_state == S_RELEASE) && w_ack_s);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else if (!w_waiting) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != TO_MAX) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
            if (r_wait_cnt == TO_MAX - 1'b1) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign o_timeout = r_timeout;
`else
    assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Bench for cdc_handshake_tx: transfer-level model driven by the recorded i_xack history,
// a behavioural destination responder, and randomized traffic.
module tb_cdc_handshake_tx;
    localparam int WIDTH = 8;
    localparam int SYNC  = 2;
    localparam int TOC   = 16;
`ifdef CDC_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             i_rst = 1'b0;
    logic             i_valid = 1'b0;
    logic [WIDTH-1:0] i_data = '0;
    logic             i_xack = 1'b0;
    logic             o_ready, o_xreq, o_done, o_busy, o_timeout;
    logic [WIDTH-1:0] o_xdata;

    cdc_handshake_tx #(
        .WIDTH(WIDTH), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TOC)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
        .o_ready(o_ready), .o_xreq(o_xreq), .o_xdata(o_xdata), .i_xack(i_xack),
        .o_done(o_done), .o_busy(o_busy), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: phase of the current transfer and the i_xack value held after each edge
    int             cyc = 0;
    int             rst_last = 0;
    bit             xh [256];
    int             ph = 0;
    logic [7:0]     m_xdata = '0;
    bit             m_done = 1'b0;
    int             wcnt = 0;
    bit             m_to = 1'b0;
    logic [7:0]     acc_q [$];
    logic [7:0]     xlog [$];

    int             done_seen = 0;
    int             viol = 0;
    bit             prev_xreq = 1'b0;
    logic [7:0]     prev_xdata = '0;
    bit             auto_dest = 1'b0;
    int             d_up = 2, d_dn = 2, dcnt = 0;
    int             xack_rise_cyc = 0, xreq_fall_cyc = 0;

    function automatic logic [12:0] exp_vec();
        return {ph == 1, ph == 0, ph != 0, m_done, TO_EN && m_to, m_xdata};
    endfunction

    task automatic tick();
        logic       v, r;
        logic [7:0] d;
        bit         ack_seen;
        v = i_valid; r = i_rst; d = i_data;
        xh[cyc % 256] = i_xack;
        @(posedge clk);
        cyc++;
        if (r) begin
            ph = 0; m_xdata = '0; m_done = 1'b0; wcnt = 0; m_to = 1'b0; rst_last = cyc;
        end else begin
            // The edge acts on i_xack as it stood SYNC_STAGES edges earlier
            ack_seen = (cyc - SYNC > rst_last) ? xh[(cyc - SYNC - 1) % 256] : 1'b0;
            m_done = 1'b0;
            if (ph == 0) begin
                if (v) begin ph = 1; m_xdata = d; wcnt = 0; acc_q.push_back(d); end
            end else if (ph == 1 && ack_seen) begin
                ph = 2; wcnt = 0;
            end else if (ph == 2 && !ack_seen) begin
                ph = 0; m_done = 1'b1;
            end else begin
                if (wcnt < TOC) wcnt++;
                if (wcnt == TOC) m_to = 1'b1;
            end
        end
        #1;
        if (o_done === 1'b1) done_seen++;
        if (prev_xreq && o_xreq === 1'b1 && o_xdata !== prev_xdata) viol++;
        if (o_xreq === 1'b1 && !prev_xreq) xlog.push_back(o_xdata);
        if (prev_xreq && o_xreq !== 1'b1) xreq_fall_cyc = cyc;
        prev_xreq = (o_xreq === 1'b1);
        prev_xdata = o_xdata;
        if (auto_dest) begin
            if (!i_xack) begin
                if (o_xreq === 1'b1) begin
                    dcnt++;
                    if (dcnt >= d_up) begin i_xack = 1'b1; dcnt = 0; xack_rise_cyc = cyc; end
                end else dcnt = 0;
            end else begin
                if (o_xreq !== 1'b1) begin
                    dcnt++;
                    if (dcnt >= d_dn) begin i_xack = 1'b0; dcnt = 0; end
                end else dcnt = 0;
            end
        end
    endtask

    task automatic test_reset();
        #2 i_rst = 1'b1;
        repeat (3) tick();
        i_rst = 1'b0;
        tick();
        checks++;
        if ({o_xreq, o_busy, o_ready, o_done, o_timeout, o_xdata} !== {5'b00100, 8'h00}) begin
            errors++;
            $display("FAIL reset_values: got %b/%h required 00100/00",
                     {o_xreq, o_busy, o_ready, o_done, o_timeout}, o_xdata);
        end
        checks++;
        if (done_seen != 0) begin
            errors++; $display("FAIL reset_no_done: got %0d pulses required 0", done_seen);
        end
    endtask

    task automatic test_single();
        int base;
        int n;
        auto_dest = 1'b1; d_up = 2; d_dn = 2; dcnt = 0;
        base = done_seen;
        i_valid = 1'b1; i_data = 8'hA5;
        tick();
        i_valid = 1'b0; i_data = 8'($urandom);
        checks++;
        if (o_xreq !== 1'b1 || o_xdata !== 8'hA5) begin
            errors++; $display("FAIL single_accept: got xreq=%b xdata=%h required 1/a5", o_xreq, o_xdata);
        end
        n = 0;
        while (ph != 0 && n < 40) begin
            tick(); n++;
            checks++;
            if ({o_xreq, o_ready, o_busy, o_done, o_timeout, o_xdata} !== exp_vec()) begin
                errors++;
                $display("FAIL single_cycle: got %h required %h at cycle %0d",
                         {o_xreq, o_ready, o_busy, o_done, o_timeout, o_xdata}, exp_vec(), cyc);
            end
        end
        checks++;
        if (ph != 0) begin errors++; $display("FAIL single_bound: transfer still open after %0d cycles", n); end
        checks++;
        if (xreq_fall_cyc - xack_rise_cyc != SYNC + 1) begin
            errors++;
            $display("FAIL single_ack_latency: got %0d required %0d", xreq_fall_cyc - xack_rise_cyc, SYNC + 1);
        end
        checks++;
        if (done_seen - base != 1 || o_ready !== 1'b1 || viol != 0) begin
            errors++;
            $display("FAIL single_end: got done=%0d ready=%b viol=%0d required 1/1/0",
                     done_seen - base, o_ready, viol);
        end
    endtask

    task automatic test_stream();
        logic [7:0] s [3] = '{8'h01, 8'h02, 8'h03};
        int         idx = 0;
        int         base = done_seen;
        int         lbase = xlog.size();
        logic       rdy;
        auto_dest = 1'b1; d_up = $urandom_range(0, 3); d_dn = $urandom_range(0, 3); dcnt = 0;
        i_valid = 1'b1; i_data = s[0];
        for (int n = 0; n < 200 && !(idx == 3 && ph == 0); n++) begin
            rdy = o_ready;
            tick();
            checks++;
            if ({o_xreq, o_ready, o_busy, o_done, o_timeout, o_xdata} !== exp_vec()) begin
                errors++;
                $display("FAIL stream_cycle: got %h required %h at cycle %0d",
                         {o_xreq, o_ready, o_busy, o_done, o_timeout, o_xdata}, exp_vec(), cyc);
            end
            if (rdy === 1'b1) begin
                idx++;
                if (idx < 3) i_data = s[idx];
                else i_valid = 1'b0;
            end
        end
        i_valid = 1'b0;
        checks++;
        if (xlog.size() - lbase != 3 || done_seen - base != 3 || viol != 0) begin
            errors++;
            $display("FAIL stream_counts: got words=%0d done=%0d viol=%0d required 3/3/0",
                     xlog.size() - lbase, done_seen - base, viol);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (xlog[lbase + i] !== s[i]) begin
                    errors++; $display("FAIL stream_word%0d: got %h required %h", i, xlog[lbase + i], s[i]);
                end
            end
        end
    endtask

    task automatic test_stale_ack();
        int base = done_seen;
        auto_dest = 1'b0; i_xack = 1'b1;
        for (int n = 0; n < 14; n++) begin
            if (n == 5) begin i_valid = 1'b1; i_data = 8'h3C; end
            if (n == 6) i_valid = 1'b0;
            tick();
            checks++;
            if ({o_xreq, o_ready, o_busy, o_done, o_timeout, o_xdata} !== exp_vec()) begin
                errors++;
                $display("FAIL stale_cycle: got %h required %h at cycle %0d",
                         {o_xreq, o_ready, o_busy, o_done, o_timeout, o_xdata}, exp_vec(), cyc);
            end
            if (n == 6) begin
                checks++;
                if (o_xreq !== 1'b0 || o_busy !== 1'b1 || o_xdata !== 8'h3C) begin
                    errors++;
                    $display("FAIL stale_release: got xreq=%b busy=%b xdata=%h required 0/1/3c",
                             o_xreq, o_busy, o_xdata);
                end
            end
        end
        i_xack = 1'b0;
        for (int n = 0; n < 10 && ph != 0; n++) begin
            tick();
            checks++;
            if ({o_xreq, o_ready, o_busy, o_done, o_timeout, o_xdata} !== exp_vec()) begin
                errors++;
                $display("FAIL stale_drop: got %h required %h at cycle %0d",
                         {o_xreq, o_ready, o_busy, o_done, o_timeout, o_xdata}, exp_vec(), cyc);
            end
        end
        checks++;
        if (done_seen - base != 1) begin
            errors++; $display("FAIL stale_done: got %0d pulses required 1", done_seen - base);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        auto_dest = 1'b0; i_xack = 1'b0;
        i_valid = 1'b1; i_data = 8'h77;
        tick();
        i_valid = 1'b0;
        repeat (2) tick();
        checks++;
        if (o_xreq !== 1'b1 || o_xdata !== 8'h77) begin
            errors++; $display("FAIL reset_mid_setup: got xreq=%b xdata=%h required 1/77", o_xreq, o_xdata);
        end
        base = done_seen;
        #2 i_rst = 1'b1;
        #1;
        checks++;
        if (o_xreq !== 1'b0 || o_xdata !== 8'h00 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_immediate: got xreq=%b xdata=%h busy=%b required 0/00/0",
                     o_xreq, o_xdata, o_busy);
        end
        repeat (2) tick();
        i_rst = 1'b0;
        repeat (3) begin
            tick();
            checks++;
            if ({o_xreq, o_ready, o_busy, o_done, o_timeout, o_xdata} !== exp_vec()) begin
                errors++;
                $display("FAIL reset_mid_after: got %h required %h at cycle %0d",
                         {o_xreq, o_ready, o_busy, o_done, o_timeout, o_xdata}, exp_vec(), cyc);
            end
        end
        checks++;
        if (done_seen != base || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_nodone: got done=%0d ready=%b required 0/1", done_seen - base, o_ready);
        end
    endtask

    task automatic test_random();
        int   base = done_seen;
        int   count = 0;
        int   n = 0;
        logic rdy, v;
        auto_dest = 1'b1; dcnt = 0;
        while (n < 4000 && !(count >= 30 && ph == 0)) begin
            if (ph == 0 && !i_xack) begin d_up = $urandom_range(0, 4); d_dn = $urandom_range(0, 4); end
            i_valid = ($urandom_range(0, 2) != 0) && (count < 30);
            i_data = 8'($urandom);
            rdy = o_ready; v = i_valid;
            tick(); n++;
            if (rdy === 1'b1 && v) count++;
            checks++;
            if ({o_xreq, o_ready, o_busy, o_done, o_timeout, o_xdata} !== exp_vec()) begin
                errors++;
                $display("FAIL random_cycle: got %h required %h at cycle %0d",
                         {o_xreq, o_ready, o_busy, o_done, o_timeout, o_xdata}, exp_vec(), cyc);
            end
        end
        i_valid = 1'b0;
        checks++;
        if (count != 30 || ph != 0 || done_seen - base != 30) begin
            errors++;
            $display("FAIL random_counts: got accepted=%0d done=%0d required 30/30", count, done_seen - base);
        end
        checks++;
        if (xlog.size() != acc_q.size()) begin
            errors++; $display("FAIL random_words: got %0d words required %0d", xlog.size(), acc_q.size());
        end else begin
            for (int i = 0; i < acc_q.size(); i++) begin
                if (xlog[i] !== acc_q[i]) begin
                    errors++; $display("FAIL random_word%0d: got %h required %h", i, xlog[i], acc_q[i]);
                end
            end
        end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL random_stable: got %0d data changes required 0", viol); end
    endtask

    task automatic test_timeout();
        int base = done_seen;
        auto_dest = 1'b0; i_xack = 1'b0;
        i_valid = 1'b1; i_data = 8'h5A;
        tick();
        i_valid = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            checks++;
            if ({o_xreq, o_ready, o_busy, o_done, o_timeout, o_xdata} !== exp_vec()) begin
                errors++;
                $display("FAIL timeout_cycle: got %h required %h at wait %0d",
                         {o_xreq, o_ready, o_busy, o_done, o_timeout, o_xdata}, exp_vec(), n);
            end
            if (n == 15 || n == 16) begin
                checks++;
                if (o_timeout !== (TO_EN && n == 16) || o_xreq !== 1'b1) begin
                    errors++;
                    $display("FAIL timeout_edge: got timeout=%b xreq=%b at wait %0d required %b/1",
                             o_timeout, o_xreq, n, TO_EN && n == 16);
                end
            end
        end
        i_xack = 1'b1;
        for (int n = 0; n < 10 && ph != 2; n++) tick();
        i_xack = 1'b0;
        for (int n = 0; n < 10 && ph != 0; n++) begin
            tick();
            checks++;
            if ({o_xreq, o_ready, o_busy, o_done, o_timeout, o_xdata} !== exp_vec()) begin
                errors++;
                $display("FAIL timeout_finish: got %h required %h at cycle %0d",
                         {o_xreq, o_ready, o_busy, o_done, o_timeout, o_xdata}, exp_vec(), cyc);
            end
        end
        checks++;
        if (done_seen - base != 1 || o_timeout !== TO_EN) begin
            errors++;
            $display("FAIL timeout_sticky: got done=%0d timeout=%b required 1/%b",
                     done_seen - base, o_timeout, TO_EN);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_stale_ack();
        test_reset_mid();
        test_random();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
